// File: rtl/fft_stream_ctrl_if.sv
// Sample stream bundle for the FFT frame controller: input stream toward the
// controller and output stream away from it.
interface fft_stream_ctrl_if #(
    parameter int MSB = 16,
    parameter int LN  = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [MSB-1:0] in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [MSB-1:0] out_data;
    logic [LN-1:0]  out_index;
    logic           out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fft_stream_ctrl.sv
// Frame controller for an iterative radix-2 FFT: streams a frame into a register
// buffer, runs log2(N) engine passes over it and streams the result back out.
module fft_stream_ctrl #(
    parameter int N          = 16,
    parameter int MSB        = 16,
    parameter bit BITREV_OUT = 1'b1,
    localparam int LN        = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_stream_ctrl_if.slave     io,
    output logic                 eng_start,
    output logic [LN-1:0]        eng_stage,
    output logic [MSB*N-1:0]     eng_data_out,
    input  logic [MSB*N-1:0]     eng_data_in,
    input  logic                 eng_done,
    output logic                 busy,
    output logic                 frame_err
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    localparam logic [LN-1:0] LAST_IDX  = LN'(N - 1);
    localparam logic [LN-1:0] LAST_STG  = LN'(LN - 1);

    function automatic logic [LN-1:0] bitrev(input logic [LN-1:0] v);
        logic [LN-1:0] r;
        for (int i = 0; i < LN; i++) begin
            r[i] = v[LN-1-i];
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [LN-1:0]  cnt_q, cnt_d;
    logic [LN-1:0]  stage_q, stage_d;
    logic           err_q, err_d;
    logic           in_ready_q, in_ready_d;
    logic [MSB-1:0] buf_q [N];
    logic           wr_en_s, load_all_s, in_hs_s;
    logic [LN-1:0]  rd_idx_s;

    // Next-state, counter and buffer-write decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        err_d      = err_q;
        wr_en_s    = 1'b0;
        load_all_s = 1'b0;
        in_hs_s    = io.in_valid && in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (in_hs_s) begin
                    wr_en_s = 1'b1;
                    if (io.in_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = LN'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_hs_s) begin
                    wr_en_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        state_d = S_START;
                    end else if (io.in_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + LN'(1);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    load_all_s = 1'b1;
                    if (stage_q == LAST_STG) begin
                        cnt_d   = '0;
                        state_d = S_UNLOAD;
                    end else begin
                        stage_d = stage_q + LN'(1);
                        state_d = S_START;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_UNLOAD: begin
                if (io.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + LN'(1);
                    end
                end else begin
                    state_d = S_UNLOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stage_q    <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Sample buffer: single-entry stream writes or whole-frame engine write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load_all_s) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= eng_data_in[MSB*i +: MSB];
            end
        end else if (wr_en_s) begin
            buf_q[cnt_q] <= io.in_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_eng_out
        assign eng_data_out[MSB*g +: MSB] = buf_q[g];
    end

    assign rd_idx_s     = BITREV_OUT ? bitrev(cnt_q) : cnt_q;
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = (state_q == S_UNLOAD);
    assign io.out_data  = buf_q[rd_idx_s];
    assign io.out_index = cnt_q;
    assign io.out_last  = (state_q == S_UNLOAD) && (cnt_q == LAST_IDX);
    assign eng_start    = (state_q == S_START);
    assign eng_stage    = stage_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_err    = err_q;
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl: natural-order instance with a "+1" engine,
// bit-reversed instance with an identity engine.
module tb_fft_stream_ctrl;
    localparam int N = 16, MSB = 16, LN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_stream_ctrl_if #(.MSB(MSB), .LN(LN)) if0 (), if1 ();

    logic             es0, es1, busy0, busy1, err0, err1;
    logic             ed0_m, ed1_m;
    logic             spur0 = 1'b0;
    logic [LN-1:0]    stg0, stg1;
    logic [MSB*N-1:0] edo0, edi0, edo1, edi1;
    int               starts0 = 0;
    logic [LN-1:0]    stage_seen [64];
    int               errors = 0, checks = 0;

    fft_stream_ctrl #(.N(N), .MSB(MSB), .BITREV_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io(if0.slave),
        .eng_start(es0), .eng_stage(stg0), .eng_data_out(edo0),
        .eng_data_in(edi0), .eng_done(ed0_m | spur0),
        .busy(busy0), .frame_err(err0)
    );

    fft_stream_ctrl #(.N(N), .MSB(MSB), .BITREV_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(if1.slave),
        .eng_start(es1), .eng_stage(stg1), .eng_data_out(edo1),
        .eng_data_in(edi1), .eng_done(ed1_m),
        .busy(busy1), .frame_err(err1)
    );

    // 1-cycle engines: result recomputed every cycle, done follows start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed0_m <= 1'b0;
            ed1_m <= 1'b0;
        end else begin
            ed0_m <= es0;
            ed1_m <= es1;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            edi0[MSB*i +: MSB] <= edo0[MSB*i +: MSB] + 16'd1;
            edi1[MSB*i +: MSB] <= edo1[MSB*i +: MSB];
        end
        if (es0) begin
            stage_seen[starts0 % 64] <= stg0;
            starts0 <= starts0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic push(input int sel, input logic [15:0] d, input bit last, input int gap);
        int t = 0;
        logic r;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        if (sel == 0) begin
            if0.in_valid = 1'b1; if0.in_data = d; if0.in_last = last;
        end else begin
            if1.in_valid = 1'b1; if1.in_data = d; if1.in_last = last;
        end
        r = (sel == 0) ? if0.in_ready : if1.in_ready;
        while (!r && t < 200) begin
            @(negedge clk);
            t++;
            r = (sel == 0) ? if0.in_ready : if1.in_ready;
        end
        if (!r) chk("push_timeout", {31'd0, r}, 32'd1);
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0; if0.in_last = 1'b0;
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
    endtask

    task automatic push_frame(input int sel, input int base, input int gapmax);
        for (int i = 0; i < N; i++) begin
            push(sel, 16'(base + i), (i == N - 1), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic pull(input int sel, input bit toggle, input logic [15:0] want [16], input string tag);
        int k = 0, t = 0;
        bit ph = 1'b0, hold = 1'b0, rdy;
        logic v, l;
        logic [15:0] d, hd;
        logic [3:0] x, hx;
        while (k < N && t < 3000) begin
            @(negedge clk);
            t++;
            v = (sel == 0) ? if0.out_valid : if1.out_valid;
            d = (sel == 0) ? if0.out_data  : if1.out_data;
            x = (sel == 0) ? if0.out_index : if1.out_index;
            l = (sel == 0) ? if0.out_last  : if1.out_last;
            if (hold) begin
                chk({tag, "_hold_valid"}, {31'd0, v}, 32'd1);
                chk({tag, "_hold_data"}, {16'd0, d}, {16'd0, hd});
                chk({tag, "_hold_idx"}, {28'd0, x}, {28'd0, hx});
            end
            rdy = toggle ? ph : 1'b1;
            ph = ~ph;
            if (sel == 0) if0.out_ready = rdy; else if1.out_ready = rdy;
            hold = 1'b0;
            if (v && rdy) begin
                chk({tag, "_data"}, {16'd0, d}, {16'd0, want[k]});
                chk({tag, "_idx"}, {28'd0, x}, 32'(k));
                chk({tag, "_last"}, {31'd0, l}, {31'd0, (k == N - 1)});
                k++;
            end else if (v) begin
                hold = 1'b1; hd = d; hx = x;
            end
        end
        if (k < N) chk({tag, "_timeout"}, 32'(k), 32'(N));
        @(negedge clk);
        chk({tag, "_valid_after"}, {31'd0, (sel == 0) ? if0.out_valid : if1.out_valid}, 32'd0);
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
    endtask

    task automatic pulse_spur();
        @(negedge clk);
        spur0 = 1'b1;
        @(negedge clk);
        spur0 = 1'b0;
    endtask

    initial begin
        logic [15:0] want [16];
        logic [3:0] kk;
        int base, t;

        if0.in_valid = 1'b0; if0.in_data = '0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, if0.out_last}, 32'd0);
        chk("rst_eng_start", {31'd0, es0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_frame_err", {31'd0, err0}, 32'd0);
        chk("rst_stage", {28'd0, stg0}, 32'd0);
        rst_n = 1'b1;

        // nominal: +1 engine over 4 stages
        base = starts0;
        push_frame(0, 0, 0);
        @(negedge clk);
        chk("nom_in_ready_low", {31'd0, if0.in_ready}, 32'd0);
        chk("nom_busy", {31'd0, busy0}, 32'd1);
        for (int i = 0; i < N; i++) want[i] = 16'(i + 4);
        pull(0, 1'b0, want, "nom");
        chk("nom_starts", 32'(starts0 - base), 32'd4);
        for (int j = 0; j < 4; j++) chk("nom_stage_seq", {28'd0, stage_seen[(base + j) % 64]}, 32'(j));
        chk("nom_busy_end", {31'd0, busy0}, 32'd0);

        // spurious eng_done during LOAD and UNLOAD
        for (int i = 0; i < 8; i++) push(0, 16'(100 + i), 1'b0, 0);
        pulse_spur();
        for (int i = 8; i < N; i++) push(0, 16'(100 + i), (i == N - 1), 0);
        t = 0;
        while (!if0.out_valid && t < 200) begin @(negedge clk); t++; end
        chk("spur_reach_unload", {31'd0, if0.out_valid}, 32'd1);
        pulse_spur();
        for (int i = 0; i < N; i++) want[i] = 16'(104 + i);
        pull(0, 1'b0, want, "spur");

        // back-pressure on both streams
        push_frame(0, 200, 3);
        for (int i = 0; i < N; i++) want[i] = 16'(204 + i);
        pull(0, 1'b1, want, "bp");

        // early last on sample 5, then a full frame
        base = starts0;
        for (int i = 0; i < 6; i++) push(0, 16'(i), (i == 5), 0);
        @(negedge clk);
        chk("early_err", {31'd0, err0}, 32'd1);
        chk("early_busy", {31'd0, busy0}, 32'd0);
        chk("early_no_start", 32'(starts0 - base), 32'd0);
        push_frame(0, 300, 0);
        for (int i = 0; i < N; i++) want[i] = 16'(304 + i);
        pull(0, 1'b0, want, "after_early");
        chk("early_err_sticky", {31'd0, err0}, 32'd1);

        // reset while waiting on stage 2
        push_frame(0, 500, 0);
        t = 0;
        while (!(busy0 && stg0 == 4'd2 && !es0) && t < 200) begin @(negedge clk); t++; end
        chk("mid_wait_reached", {28'd0, stg0}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_stage", {28'd0, stg0}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err0}, 32'd0);
        chk("mid_rst_data", {16'd0, if0.out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = starts0;
        push_frame(0, 400, 0);
        for (int i = 0; i < N; i++) want[i] = 16'(404 + i);
        pull(0, 1'b0, want, "post_rst");
        chk("post_rst_starts", 32'(starts0 - base), 32'd4);
        chk("post_rst_stage0", {28'd0, stage_seen[base % 64]}, 32'd0);

        // bit-reversed output with identity engine
        push_frame(1, 0, 0);
        for (int i = 0; i < N; i++) begin
            kk = 4'(i);
            want[i] = {12'd0, kk[0], kk[1], kk[2], kk[3]};
        end
        pull(1, 1'b0, want, "bitrev");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
